// File: rtl/multiplexer_pkg.sv
// multiplexer_pkg: scan-state encoding (IDLE=0, SCAN=1, DONE=2) plus clog2 and select-width helpers shared by multiplexer_seq
package multiplexer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} scan_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sel_w(input int ch);
    return clog2(ch) > 1 ? clog2(ch) : 1;
  endfunction
endpackage

// File: rtl/multiplexer_seq_if.sv
// multiplexer_seq_if: bus bundle (data_in/sel/in_valid/in_ready upstream, out_data/out_ch/out_err/out_valid/out_ready downstream, scan_start/scan_busy/scan_done control); slave = mux side, master = driver side
interface multiplexer_seq_if import multiplexer_pkg::*; #(parameter int W = 100, parameter int CH = 4);
  localparam int SW = sel_w(CH);
  logic [CH*W-1:0] data_in;
  logic [SW-1:0] sel;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_ch;
  logic out_err;
  logic out_valid;
  logic out_ready;
  logic scan_start;
  logic scan_busy;
  logic scan_done;
  modport master(output data_in, sel, in_valid, out_ready, scan_start,
                 input in_ready, out_data, out_ch, out_err, out_valid, scan_busy, scan_done);
  modport slave(input data_in, sel, in_valid, out_ready, scan_start,
                output in_ready, out_data, out_ch, out_err, out_valid, scan_busy, scan_done);
endinterface

// File: rtl/multiplexer_scan_ctrl.sv
// multiplexer_scan_ctrl: IDLE/SCAN/DONE auto-scan FSM; ports clk, rst, scan_start, accept in; scan_busy, scan_done, cnt (channel to select while scanning) out
module multiplexer_scan_ctrl import multiplexer_pkg::*; #(
  parameter int CH = 4,
  localparam int SW = sel_w(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_start,
  input  logic          accept,
  output logic          scan_busy,
  output logic          scan_done,
  output logic [SW-1:0] cnt
);
  localparam logic [SW-1:0] LAST = SW'(CH - 1);
  scan_state_e state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic last_acc;
  always_comb begin
    last_acc = accept && cnt_q == LAST;
    state_d = state_q == IDLE ? (scan_start ? SCAN : IDLE) :
              state_q == SCAN ? (last_acc ? DONE : SCAN) : IDLE;
    cnt_d = state_q == IDLE ? (scan_start ? '0 : cnt_q) :
            (state_q == SCAN && accept) ? (last_acc ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign scan_busy = state_q == SCAN;
  assign scan_done = state_q == DONE;
  assign cnt = cnt_q;
endmodule

// File: rtl/multiplexer_seq.sv
// multiplexer_seq: registered CH-way W-bit mux with valid/ready handshake and out-of-range flag; ports clk, rst, bus (multiplexer_seq_if.slave); auto-scan included when MULTIPLEXER_SEQ_SCAN_EN is defined
module multiplexer_seq import multiplexer_pkg::*; #(
  parameter int W = 100,
  parameter int CH = 4
) (
  input logic clk,
  input logic rst,
  multiplexer_seq_if.slave bus
);
  localparam int SW = sel_w(CH);
  localparam int PW = (1 << SW) * W;
  logic in_ready, accept, busy, done, sel_err;
  logic [SW-1:0] scan_cnt, eff_sel;
  logic [PW-1:0] padded;
  logic [W-1:0] out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic out_err_q, out_err_d, out_valid_q, out_valid_d;
  assign in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && in_ready;
`ifdef MULTIPLEXER_SEQ_SCAN_EN
  multiplexer_scan_ctrl #(.CH(CH)) u_scan (
    .clk(clk),
    .rst(rst),
    .scan_start(bus.scan_start),
    .accept(accept),
    .scan_busy(busy),
    .scan_done(done),
    .cnt(scan_cnt)
  );
`else
  assign busy = 1'b0;
  assign done = 1'b0;
  assign scan_cnt = '0;
`endif
  always_comb begin
    eff_sel = busy ? scan_cnt : bus.sel;
    sel_err = int'(eff_sel) >= CH;
    padded = PW'(bus.data_in);
    out_data_d = !accept ? out_data_q : sel_err ? '0 : padded[int'(eff_sel)*W +: W];
    out_ch_d = accept ? eff_sel : out_ch_q;
    out_err_d = accept ? sel_err : out_err_q;
    out_valid_d = accept || (out_valid_q && !bus.out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_ch_q <= '0;
      out_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      out_err_q <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_data = out_data_q;
  assign bus.out_ch = out_ch_q;
  assign bus.out_err = out_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_busy = busy;
  assign bus.scan_done = done;
endmodule

// File: tb/tb_multiplexer_seq.sv
// tb_multiplexer_seq: directed checks of multiplexer_seq (W=8, CH=4 and CH=3 instances); scan tests when MULTIPLEXER_SEQ_SCAN_EN is defined
module tb_multiplexer_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  multiplexer_seq_if #(.W(8), .CH(4)) bus4 ();
  multiplexer_seq_if #(.W(8), .CH(3)) bus3 ();
  multiplexer_seq #(.W(8), .CH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  multiplexer_seq #(.W(8), .CH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1; bus4.sel = 2'd2;
    bus3.in_valid = 1'b1; bus3.out_ready = 1'b1; bus3.sel = 2'd1;
    tick; tick;
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", bus4.out_valid); end
    vectors++; if (bus4.out_data !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h want 00", bus4.out_data); end
    vectors++; if (bus4.out_ch !== 2'd0) begin miscompares++; $display("FAIL rst_ch got %0d want 0", bus4.out_ch); end
    vectors++; if (bus4.out_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", bus4.out_err); end
    vectors++; if (bus4.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", bus4.in_ready); end
    vectors++; if (bus3.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready3 got %b want 0", bus3.in_ready); end
    vectors++; if (bus4.scan_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", bus4.scan_busy); end
    vectors++; if (bus4.scan_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", bus4.scan_done); end
    rst = 1'b0;
    bus4.in_valid = 1'b0; bus3.in_valid = 1'b0;
    tick;
    vectors++; if (bus4.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready got %b want 1", bus4.in_ready); end
  endtask

  task automatic test_select;
    bus4.data_in = 32'h44332211; bus4.out_ready = 1'b1; bus4.in_valid = 1'b1; bus4.sel = 2'd2;
    tick;
    vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL sel2_valid got %b want 1", bus4.out_valid); end
    vectors++; if (bus4.out_data !== 8'h33) begin miscompares++; $display("FAIL sel2_data got %h want 33", bus4.out_data); end
    vectors++; if (bus4.out_ch !== 2'd2) begin miscompares++; $display("FAIL sel2_ch got %0d want 2", bus4.out_ch); end
    vectors++; if (bus4.out_err !== 1'b0) begin miscompares++; $display("FAIL sel2_err got %b want 0", bus4.out_err); end
    bus4.sel = 2'd0;
    tick;
    vectors++; if (bus4.out_data !== 8'h11) begin miscompares++; $display("FAIL sel0_data got %h want 11", bus4.out_data); end
    vectors++; if (bus4.out_ch !== 2'd0) begin miscompares++; $display("FAIL sel0_ch got %0d want 0", bus4.out_ch); end
    bus4.sel = 2'd3;
    tick;
    vectors++; if (bus4.out_data !== 8'h44) begin miscompares++; $display("FAIL sel3_data got %h want 44", bus4.out_data); end
    vectors++; if (bus4.out_err !== 1'b0) begin miscompares++; $display("FAIL sel3_err got %b want 0", bus4.out_err); end
    bus4.in_valid = 1'b0;
    tick;
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got %b want 0", bus4.out_valid); end
  endtask

  task automatic test_backpressure;
    bus4.sel = 2'd1; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    tick;
    vectors++; if (bus4.out_data !== 8'h22) begin miscompares++; $display("FAIL bp_load_data got %h want 22", bus4.out_data); end
    bus4.sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus4.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus4.in_ready); end
      vectors++; if (bus4.out_data !== 8'h22) begin miscompares++; $display("FAIL bp_hold_data[%0d] got %h want 22", i, bus4.out_data); end
      vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, bus4.out_valid); end
      tick;
    end
    bus4.out_ready = 1'b1;
    #1;
    vectors++; if (bus4.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", bus4.in_ready); end
    tick;
    vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_next_valid got %b want 1", bus4.out_valid); end
    vectors++; if (bus4.out_data !== 8'h44) begin miscompares++; $display("FAIL bp_next_data got %h want 44", bus4.out_data); end
    vectors++; if (bus4.out_ch !== 2'd3) begin miscompares++; $display("FAIL bp_next_ch got %0d want 3", bus4.out_ch); end
    bus4.in_valid = 1'b0;
    tick;
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain_valid got %b want 0", bus4.out_valid); end
  endtask

  task automatic test_out_of_range;
    bus3.data_in = 24'h332211; bus3.out_ready = 1'b1; bus3.in_valid = 1'b1; bus3.sel = 2'd3;
    tick;
    vectors++; if (bus3.out_data !== 8'h00) begin miscompares++; $display("FAIL oor_data got %h want 00", bus3.out_data); end
    vectors++; if (bus3.out_err !== 1'b1) begin miscompares++; $display("FAIL oor_err got %b want 1", bus3.out_err); end
    vectors++; if (bus3.out_ch !== 2'd3) begin miscompares++; $display("FAIL oor_ch got %0d want 3", bus3.out_ch); end
    vectors++; if (bus3.out_valid !== 1'b1) begin miscompares++; $display("FAIL oor_valid got %b want 1", bus3.out_valid); end
    bus3.sel = 2'd2;
    tick;
    vectors++; if (bus3.out_data !== 8'h33) begin miscompares++; $display("FAIL ch3_top_data got %h want 33", bus3.out_data); end
    vectors++; if (bus3.out_err !== 1'b0) begin miscompares++; $display("FAIL ch3_top_err got %b want 0", bus3.out_err); end
    bus3.in_valid = 1'b0;
    tick;
  endtask

`ifdef MULTIPLEXER_SEQ_SCAN_EN
  task automatic test_scan;
    logic [7:0] exp;
    bus4.sel = 2'd1; bus4.out_ready = 1'b1; bus4.in_valid = 1'b0; bus4.scan_start = 1'b1;
    tick;
    bus4.scan_start = 1'b0;
    vectors++; if (bus4.scan_busy !== 1'b1) begin miscompares++; $display("FAIL scan_busy_start got %b want 1", bus4.scan_busy); end
    bus4.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 8'((i + 1) * 17);
      tick;
      vectors++; if (bus4.out_ch !== 2'(i)) begin miscompares++; $display("FAIL scan_ch[%0d] got %0d want %0d", i, bus4.out_ch, i); end
      vectors++; if (bus4.out_data !== exp) begin miscompares++; $display("FAIL scan_data[%0d] got %h want %h", i, bus4.out_data, exp); end
      if (i < 3) begin
        vectors++; if (bus4.scan_busy !== 1'b1) begin miscompares++; $display("FAIL scan_busy[%0d] got %b want 1", i, bus4.scan_busy); end
      end
    end
    vectors++; if (bus4.scan_done !== 1'b1) begin miscompares++; $display("FAIL scan_done got %b want 1", bus4.scan_done); end
    vectors++; if (bus4.scan_busy !== 1'b0) begin miscompares++; $display("FAIL scan_busy_done got %b want 0", bus4.scan_busy); end
    tick;
    vectors++; if (bus4.scan_done !== 1'b0) begin miscompares++; $display("FAIL scan_done_pulse got %b want 0", bus4.scan_done); end
    vectors++; if (bus4.out_ch !== 2'd1) begin miscompares++; $display("FAIL post_scan_explicit_ch got %0d want 1", bus4.out_ch); end
    bus4.in_valid = 1'b0;
    tick;
  endtask

  task automatic test_scan_gaps;
    bit vp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit sp [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int n;
    n = 0;
    bus4.sel = 2'd3; bus4.out_ready = 1'b1; bus4.in_valid = 1'b0; bus4.scan_start = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) begin
      bus4.in_valid = vp[i]; bus4.scan_start = sp[i];
      tick;
      if (vp[i]) begin
        vectors++; if (bus4.out_ch !== 2'(n)) begin miscompares++; $display("FAIL gap_ch[%0d] got %0d want %0d", i, bus4.out_ch, n); end
        n++;
      end else begin
        vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_valid[%0d] got %b want 0", i, bus4.out_valid); end
        vectors++; if (bus4.scan_busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy[%0d] got %b want 1", i, bus4.scan_busy); end
      end
    end
    bus4.in_valid = 1'b0; bus4.scan_start = 1'b0;
    vectors++; if (bus4.scan_done !== 1'b1) begin miscompares++; $display("FAIL gap_done got %b want 1", bus4.scan_done); end
    tick;
    vectors++; if (bus4.scan_done !== 1'b0) begin miscompares++; $display("FAIL gap_done_clear got %b want 0", bus4.scan_done); end
  endtask

  task automatic test_scan_reset;
    bus4.out_ready = 1'b1; bus4.in_valid = 1'b0; bus4.scan_start = 1'b1;
    tick;
    bus4.scan_start = 1'b0; bus4.in_valid = 1'b1; bus4.sel = 2'd3;
    tick; tick;
    vectors++; if (bus4.out_ch !== 2'd1) begin miscompares++; $display("FAIL abort_pre_ch got %0d want 1", bus4.out_ch); end
    rst = 1'b1;
    tick;
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b want 0", bus4.out_valid); end
    vectors++; if (bus4.scan_busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", bus4.scan_busy); end
    vectors++; if (bus4.scan_done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", bus4.scan_done); end
    rst = 1'b0; bus4.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++; if (bus4.scan_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done[%0d] got %b want 0", i, bus4.scan_done); end
    end
    bus4.in_valid = 1'b1; bus4.sel = 2'd2;
    tick;
    vectors++; if (bus4.out_ch !== 2'd2) begin miscompares++; $display("FAIL abort_explicit_ch got %0d want 2", bus4.out_ch); end
    bus4.in_valid = 1'b0;
    tick;
  endtask
`else
  task automatic test_no_scan;
    bus4.out_ready = 1'b1; bus4.in_valid = 1'b1; bus4.sel = 2'd1; bus4.scan_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      vectors++; if (bus4.scan_busy !== 1'b0) begin miscompares++; $display("FAIL noscan_busy[%0d] got %b want 0", i, bus4.scan_busy); end
      vectors++; if (bus4.scan_done !== 1'b0) begin miscompares++; $display("FAIL noscan_done[%0d] got %b want 0", i, bus4.scan_done); end
      vectors++; if (bus4.out_ch !== 2'd1) begin miscompares++; $display("FAIL noscan_ch[%0d] got %0d want 1", i, bus4.out_ch); end
      bus4.scan_start = 1'b0;
    end
    bus4.in_valid = 1'b0;
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus4.data_in = '0; bus4.sel = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.scan_start = 1'b0;
    bus3.data_in = '0; bus3.sel = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.scan_start = 1'b0;
    test_reset;
    test_select;
    test_backpressure;
    test_out_of_range;
`ifdef MULTIPLEXER_SEQ_SCAN_EN
    test_scan;
    test_scan_gaps;
    test_scan_reset;
`else
    test_no_scan;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
